refresh_timer: RTL and testbench
================================

# refresh_timer

Upstream refresh scheduler for the DRAM controller. It free-runs on CLK and produces the refresh request (`RefReq`) and urgent-refresh (`RefUrg`) levels that the RAM controller samples on its refresh-counter interface. Each refresh period opens a request window. The urgent level is raised late in the window so the controller is forced to insert a refresh even during RAM traffic.

## Interface
- `REF_PERIOD`, default 375: CLK cycles between the start of one request window and the start of the next (15 µs at 25 MHz). Legal range is `REQ_WIDTH+3`..4095.
- `REQ_WIDTH`, default 32: length of the request window in cycles. Legal range is `URG_AFTER+1`..255.
- `URG_AFTER`, default 16: number of cycles of `RefReq`-only before `RefUrg` joins. Legal range is 1..`REQ_WIDTH-1`.
- `CLK` input, 1 bit: system clock. All logic is rising-edge.
- `nRES` input, 1 bit: asynchronous active-low reset.
- `RefReq` output, 1 bit: refresh requested. Registered.
- `RefUrg` output, 1 bit: refresh urgent. Registered. Asserted only while `RefReq` is asserted.
- `RefAck` input, 1 bit, present only with `REFRESH_ACK_EN`: a one-cycle or level indication that a refresh RAS has started.
- `RefMiss` output, 1 bit, present only with `REFRESH_ACK_EN`: sticky flag meaning at least one window expired without an acknowledge.

## Operation
- `PeriodCnt` is an up-counter of width ceil(log2(`REF_PERIOD`)). It wraps from `REF_PERIOD-1` to 0. The wrap cycle produces a one-cycle internal `Tick`.
- State machine states:
  - IDLE: `RefReq`=0, `RefUrg`=0.
  - REQ: `RefReq`=1, `RefUrg`=0.
  - URG: `RefReq`=1, `RefUrg`=1.
- `WinCnt` (8 bits) counts cycles spent in the window. It clears on entry to REQ.
- IDLE → REQ on `Tick`.
- REQ → URG when `WinCnt` = `URG_AFTER-1`.
- URG → IDLE when `WinCnt` = `REQ_WIDTH-1`.
- Without `REFRESH_ACK_EN`, the window always lasts exactly `REQ_WIDTH` cycles. The RAM controller's done-latch clears during the IDLE gap of at least 3 cycles.
- `Tick` seen in REQ or URG is impossible under legal parameters without `REFRESH_ACK_EN`. It is ignored.

## Timing
- Reset values while `nRES` is low: `PeriodCnt`=0, `WinCnt`=0, state IDLE, `RefReq`=0, `RefUrg`=0, `RefMiss`=0, `Debt`=0.
- Reset asserted mid-window drops both outputs immediately, asynchronously.
- The first `RefReq` rise follows the `REF_PERIOD`-th rising edge after `nRES` deasserts. Later rises come every `REF_PERIOD` cycles.
- `RefUrg` rises exactly `URG_AFTER` cycles after `RefReq` rises. Both fall on the same edge.
- There is no combinational path from any input to any output.

## Configuration
- `REFRESH_ACK_EN` defined: adds `RefAck`, `RefMiss`, and a 2-bit saturating `Debt` counter.
  - `RefAck` in REQ or URG moves the state to IDLE on the next edge. `RefAck` in IDLE is ignored.
  - A window that expires in URG with no `RefAck` increments `Debt` (saturating at 3) and sets `RefMiss`. `RefMiss` clears only on reset.
  - `RefAck` arriving on the expiry cycle counts as an acknowledge, so no debt is added.
  - `Tick` during REQ or URG increments `Debt`.
  - `RefAck` with `Debt`>0 decrements `Debt`.
  - Simultaneous increment and decrement of `Debt` leaves it unchanged.
  - In IDLE with `Debt`>0, a new window starts after a 3-cycle gap without waiting for `Tick`. That window enters URG directly, so `RefReq` and `RefUrg` rise together.
- `REFRESH_ACK_EN` undefined: fixed-window behaviour only. The extra ports, `Debt`, and the ack logic are absent.

## Test plan
- Defaults, reset released at t0 → `RefReq` rises after edge 375, `RefUrg` rises 16 cycles later, both fall 32 cycles after the `RefReq` rise, and the pattern repeats every 375 cycles.
- `REF_PERIOD`=20, `REQ_WIDTH`=8, `URG_AFTER`=4, `nRES` pulsed low 2 cycles into URG → both outputs fall asynchronously, and the next `RefReq` rises 20 cycles after release.
- `REFRESH_ACK_EN`, `REF_PERIOD`=20, `RefAck` pulsed 2 cycles after the `RefReq` rise → `RefReq` falls on the next edge, `RefUrg` never rises, and `Debt` stays 0.
- `REFRESH_ACK_EN`, `REF_PERIOD`=20, no `RefAck` for one window → `RefMiss`=1 and `Debt`=1, and after a 3-cycle gap `RefReq` and `RefUrg` rise together.
- `REFRESH_ACK_EN`, `REF_PERIOD`=20, no `RefAck` for 5 windows → `Debt` saturates at 3. Then 3 acks on successive windows → `Debt`=0 and `RefMiss` stays 1.
- `REFRESH_ACK_EN`, `REF_PERIOD`=20, `RefAck` on the final URG cycle → no debt increment and `RefMiss` stays 0.

Source files
------------

// File: rtl/refresh_timer.sv
// DRAM refresh scheduler: periodic request window with a late urgent phase.
// Optional REFRESH_ACK_EN adds RefAck/RefMiss and a saturating refresh debt with catch-up windows.
module refresh_timer #(
  parameter int REF_PERIOD = 375,
  parameter int REQ_WIDTH  = 32,
  parameter int URG_AFTER  = 16
) (
  input  logic CLK,
  input  logic nRES,
`ifdef REFRESH_ACK_EN
  input  logic RefAck,
  output logic RefMiss,
`endif
  output logic RefReq,
  output logic RefUrg
);

  // state | meaning: IDLE gap between windows | REQ RefReq only | URG RefReq and RefUrg
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    URG  = 2'd2
  } state_t;

  localparam int PW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(REF_PERIOD - 1);
  localparam logic [7:0]    URG_LAST    = 8'(URG_AFTER - 1);
  localparam logic [7:0]    WIN_LAST    = 8'(REQ_WIDTH - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] period_cnt;
  logic [7:0]    win_cnt;
  logic          tick;
  logic          win_end;
  logic          ack_hit;
  logic          restart;

  assign tick    = (period_cnt == PERIOD_LAST);
  assign win_end = (state == URG) && (win_cnt == WIN_LAST);

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES)     period_cnt <= '0;
    else if (tick) period_cnt <= '0;
    else           period_cnt <= period_cnt + 1'b1;
  end

  // Held at zero while idle, so every window starts counting from zero.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES)              win_cnt <= '0;
    else if (state == IDLE) win_cnt <= '0;
    else                    win_cnt <= win_cnt + 8'd1;
  end

`ifdef REFRESH_ACK_EN
  logic [1:0] debt;
  logic [1:0] gap_cnt;
  logic       in_win;
  logic       expire_miss;
  logic       debt_inc;
  logic       debt_dec;

  assign in_win      = (state != IDLE);
  assign ack_hit     = RefAck;
  assign expire_miss = win_end && !RefAck;
  assign debt_inc    = expire_miss || (tick && in_win);
  assign debt_dec    = RefAck && in_win && (debt != 2'd0);
  assign restart     = (state == IDLE) && (debt != 2'd0) && (gap_cnt == 2'd2);

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES)                                       debt <= '0;
    else if (debt_inc && !debt_dec && debt != 2'd3)  debt <= debt + 2'd1;
    else if (debt_dec && !debt_inc)                  debt <= debt - 2'd1;
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES)            RefMiss <= 1'b0;
    else if (expire_miss) RefMiss <= 1'b1;
  end

  // Idle-cycle count; a catch-up window needs three idle cycles first.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES)                gap_cnt <= '0;
    else if (in_win)          gap_cnt <= '0;
    else if (gap_cnt != 2'd3) gap_cnt <= gap_cnt + 2'd1;
  end
`else
  assign ack_hit = 1'b0;
  assign restart = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (tick)         state_nxt = REQ;
        else if (restart) state_nxt = URG;
      end
      REQ: begin
        if (ack_hit)                  state_nxt = IDLE;
        else if (win_cnt == URG_LAST) state_nxt = URG;
      end
      URG: begin
        if (ack_hit || win_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    RefReq = 1'b0;
    RefUrg = 1'b0;
    case (state)
      REQ: RefReq = 1'b1;
      URG: begin
        RefReq = 1'b1;
        RefUrg = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_refresh_timer.sv
// Bench for refresh_timer: default-parameter instance plus a short-period instance.
// Expected output edges are queued by the stimulus and matched by per-instance monitors.
module tb_refresh_timer;

  logic CLK = 1'b0;
  logic nres_a, nres_b;
  logic req_a, urg_a, req_b, urg_b;
`ifdef REFRESH_ACK_EN
  logic ack_a, ack_b, miss_a, miss_b;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  localparam int END_CYC = 1175;
  localparam int RA = 3;

  typedef struct {
    int   cyc;
    logic req;
    logic urg;
  } ev_t;

  ev_t exp_a[$];
  ev_t exp_b[$];
  ev_t ea, eb;
  logic [1:0] prev_a = 2'b00;
  logic [1:0] prev_b = 2'b00;

  refresh_timer dut_a (
    .CLK    (CLK),
    .nRES   (nres_a),
`ifdef REFRESH_ACK_EN
    .RefAck (ack_a),
    .RefMiss(miss_a),
`endif
    .RefReq (req_a),
    .RefUrg (urg_a)
  );

  refresh_timer #(.REF_PERIOD(20), .REQ_WIDTH(8), .URG_AFTER(4)) dut_b (
    .CLK    (CLK),
    .nRES   (nres_b),
`ifdef REFRESH_ACK_EN
    .RefAck (ack_b),
    .RefMiss(miss_b),
`endif
    .RefReq (req_b),
    .RefUrg (urg_b)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_ev(input string name, input ev_t e, input logic r, input logic u);
    n_checks++;
    if (e.cyc != cyc || e.req !== r || e.urg !== u) begin
      n_errors++;
      $display("FAIL %s: got req=%0b urg=%0b at cycle %0d, expected req=%0b urg=%0b at cycle %0d",
               name, r, u, cyc, e.req, e.urg, e.cyc);
    end
  endtask

  task automatic push_a(input int c, input logic r, input logic u);
    exp_a.push_back('{c, r, u});
  endtask

  task automatic push_b(input int c, input logic r, input logic u);
    exp_b.push_back('{c, r, u});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if ({req_a, urg_a} !== prev_a) begin
      prev_a = {req_a, urg_a};
      if (exp_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_unexpected: got req=%0b urg=%0b at cycle %0d, expected no change", req_a, urg_a, cyc);
      end else begin
        ea = exp_a.pop_front();
        check_ev("a_event", ea, req_a, urg_a);
      end
    end
  end

  always @(negedge CLK) begin
    if ({req_b, urg_b} !== prev_b) begin
      prev_b = {req_b, urg_b};
      if (exp_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected: got req=%0b urg=%0b at cycle %0d, expected no change", req_b, urg_b, cyc);
      end else begin
        eb = exp_b.pop_front();
        check_ev("b_event", eb, req_b, urg_b);
      end
    end
  end

`ifdef REFRESH_ACK_EN
  // Instance A acknowledges on the last URG cycle of every window.
  initial begin
    ack_a = 1'b0;
    forever begin
      @(negedge CLK);
      ack_a = (cyc >= RA + 375 + 31) && (((cyc - RA - 375 - 31) % 375) == 0);
    end
  end
`endif

  initial begin
    int b;
    nres_a = 1'b0;
    nres_b = 1'b0;
`ifdef REFRESH_ACK_EN
    ack_b = 1'b0;
`endif
    wait_cyc(1);
    check("a_reset_req", int'(req_a), 0);
    check("a_reset_urg", int'(urg_a), 0);
    check("b_reset_req", int'(req_b), 0);
    check("b_reset_urg", int'(urg_b), 0);
`ifdef REFRESH_ACK_EN
    check("a_reset_miss", int'(miss_a), 0);
    check("b_reset_miss", int'(miss_b), 0);
`endif

    wait_cyc(RA);
    nres_a = 1'b1;
    nres_b = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      push_a(RA + 375 * k, 1'b1, 1'b0);
      push_a(RA + 375 * k + 16, 1'b1, 1'b1);
      push_a(RA + 375 * k + 32, 1'b0, 1'b0);
    end
    push_b(RA + 20, 1'b1, 1'b0);
    push_b(RA + 24, 1'b1, 1'b1);
    push_b(RA + 26, 1'b0, 1'b0);

    // Reset B two cycles into URG; outputs must drop before the next edge.
    wait_cyc(RA + 25);
    @(posedge CLK);
    #2;
    nres_b = 1'b0;
    #1;
    check("b_async_req", int'(req_b), 0);
    check("b_async_urg", int'(urg_b), 0);

    b = RA + 29;
    wait_cyc(b);
    nres_b = 1'b1;

`ifdef REFRESH_ACK_EN
    push_b(b + 20, 1'b1, 1'b0);
    push_b(b + 23, 1'b0, 1'b0);
    wait_cyc(b + 22); ack_b = 1'b1;
    wait_cyc(b + 23); ack_b = 1'b0;
    wait_cyc(b + 25);
    check("early_ack_debt", int'(dut_b.debt), 0);

    push_b(b + 40, 1'b1, 1'b0);
    push_b(b + 44, 1'b1, 1'b1);
    push_b(b + 48, 1'b0, 1'b0);
    wait_cyc(b + 47); ack_b = 1'b1;
    wait_cyc(b + 48); ack_b = 1'b0;
    wait_cyc(b + 50);
    check("last_cycle_ack_debt", int'(dut_b.debt), 0);
    check("last_cycle_ack_miss", int'(miss_b), 0);

    push_b(b + 60, 1'b1, 1'b0);
    push_b(b + 64, 1'b1, 1'b1);
    push_b(b + 68, 1'b0, 1'b0);
    push_b(b + 71, 1'b1, 1'b1);
    push_b(b + 73, 1'b0, 1'b0);
    wait_cyc(b + 69);
    check("miss_debt", int'(dut_b.debt), 1);
    check("miss_flag", int'(miss_b), 1);
    wait_cyc(b + 72); ack_b = 1'b1;
    wait_cyc(b + 73); ack_b = 1'b0;
    wait_cyc(b + 75);
    check("catchup_ack_debt", int'(dut_b.debt), 0);

    push_b(b + 80, 1'b1, 1'b0);   push_b(b + 84, 1'b1, 1'b1);  push_b(b + 88, 1'b0, 1'b0);
    push_b(b + 91, 1'b1, 1'b1);   push_b(b + 99, 1'b0, 1'b0);
    push_b(b + 100, 1'b1, 1'b0);  push_b(b + 104, 1'b1, 1'b1); push_b(b + 108, 1'b0, 1'b0);
    push_b(b + 111, 1'b1, 1'b1);  push_b(b + 119, 1'b0, 1'b0);
    push_b(b + 120, 1'b1, 1'b0);  push_b(b + 124, 1'b1, 1'b1); push_b(b + 128, 1'b0, 1'b0);
    push_b(b + 131, 1'b1, 1'b1);  push_b(b + 133, 1'b0, 1'b0);
    push_b(b + 136, 1'b1, 1'b1);  push_b(b + 138, 1'b0, 1'b0);
    push_b(b + 140, 1'b1, 1'b0);  push_b(b + 143, 1'b0, 1'b0);
    wait_cyc(b + 89);
    check("sat_debt_1", int'(dut_b.debt), 1);
    wait_cyc(b + 129);
    check("sat_debt_3", int'(dut_b.debt), 3);
    wait_cyc(b + 132); ack_b = 1'b1;
    wait_cyc(b + 133); ack_b = 1'b0;
    wait_cyc(b + 135);
    check("repay_debt_2", int'(dut_b.debt), 2);
    wait_cyc(b + 137); ack_b = 1'b1;
    wait_cyc(b + 138); ack_b = 1'b0;
    wait_cyc(b + 142); ack_b = 1'b1;
    wait_cyc(b + 143); ack_b = 1'b0;
    wait_cyc(b + 150);
    check("repay_debt_0", int'(dut_b.debt), 0);
    check("repay_miss_sticky", int'(miss_b), 1);
    nres_b = 1'b0;
`else
    for (int k = 1; k <= 3; k++) begin
      push_b(b + 20 * k, 1'b1, 1'b0);
      push_b(b + 20 * k + 4, 1'b1, 1'b1);
      push_b(b + 20 * k + 8, 1'b0, 1'b0);
    end
    wait_cyc(b + 75);
    nres_b = 1'b0;
`endif

    wait_cyc(END_CYC);
    check("a_pending_events", exp_a.size(), 0);
    check("b_pending_events", exp_b.size(), 0);
`ifdef REFRESH_ACK_EN
    check("a_final_miss", int'(miss_a), 0);
    check("a_final_debt", int'(dut_a.debt), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
